// File: rtl/mskaes_arb_pkg.sv
// Shared definitions for the masked-AES core arbiter.
//   - arb_state_e : arbiter FSM states (RUN, DRAIN, DONE, HOLD), with encodings
//                   also exported as localparam constants for legacy users.
//   - rr_pick     : round-robin winner search over up to MAX_REQ requesters.
package mskaes_arb_pkg;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE,
    HOLD  = ST_HOLD
  } arb_state_e;

  localparam int unsigned MAX_REQ = 8;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], scanning upward from ptr with wrap-around.
  // ptr must be < n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int unsigned        n);
    rr_pick_t    r;
    int unsigned j;
    r = '0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= n) j = j - n;
      if ((k < n) && !r.found && valid[j[2:0]]) begin
        r.found = 1'b1;
        r.idx   = j[2:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mskaes_tag_fifo.sv
// In-order tag FIFO holding the requester ID of each block in the core.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   i_push/i_data : enqueue a tag (ignored when full unless popping too)
//   i_pop         : dequeue the head (ignored when empty)
//   o_head        : current head tag
//   o_count       : occupancy, 0..DEPTH
module mskaes_tag_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_head,
  output logic [CW-1:0] o_count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      if (w_do_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_count;

endmodule

// File: rtl/mskaes_core_arbiter.sv
// Round-robin scheduler sharing one round-based masked AES-128 core among
// NREQ requesters, with in-order ID tagging of results and a drain sequence.
//   clk, rst                         : clock, synchronous active-high reset
//   req_valid / req_ready            : per-requester offer / one-hot grant
//   req_sh_plaintext / req_sh_key    : concatenated sharings, slice i = requester i
//   core_nrst                        : core reset (~rst)
//   core_valid_in / core_ready       : core input handshake
//   core_sh_plaintext / core_sh_key  : granted requester's sharings, zero otherwise
//   core_cipher_valid / core_sh_ciphertext : core result
//   out_valid / out_id / out_sh_ciphertext : tagged result, no backpressure
//   flush_req / flush_done           : drain request level / completion pulse
//   inflight                         : tag FIFO occupancy
//   err_underflow                    : sticky, result seen with no block in flight
module mskaes_core_arbiter
  import mskaes_arb_pkg::*;
#(
  parameter int unsigned d       = 2,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned IDW     = $clog2(NREQ)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NREQ-1:0]                   req_valid,
  output logic [NREQ-1:0]                   req_ready,
  input  logic [NREQ*128*d-1:0]             req_sh_plaintext,
  input  logic [NREQ*128*d-1:0]             req_sh_key,
  output logic                              core_nrst,
  output logic                              core_valid_in,
  input  logic                              core_ready,
  output logic [128*d-1:0]                  core_sh_plaintext,
  output logic [128*d-1:0]                  core_sh_key,
  input  logic                              core_cipher_valid,
  input  logic [128*d-1:0]                  core_sh_ciphertext,
  output logic                              out_valid,
  output logic [IDW-1:0]                    out_id,
  output logic [128*d-1:0]                  out_sh_ciphertext,
  input  logic                              flush_req,
  output logic                              flush_done,
  output logic [$clog2(LATENCY+1)-1:0]      inflight,
  output logic                              err_underflow
);

  localparam int unsigned SW = 128 * d;
  localparam int unsigned CW = $clog2(LATENCY + 1);

  arb_state_e     r_state;
  arb_state_e     w_state_nxt;
  logic [IDW-1:0] r_rr_ptr;
  logic           r_flush_done;
  logic           r_err_underflow;

  logic [MAX_REQ-1:0] w_valid8;
  logic [2:0]         w_ptr3;
  rr_pick_t           w_pick;
  logic               w_eligible;
  logic               w_grant;
  logic               w_pop;
  logic [IDW-1:0]     w_head;
  logic [CW-1:0]      w_count;
  logic [SW-1:0]      w_pt;
  logic [SW-1:0]      w_key;

  always_comb begin
    w_valid8              = '0;
    w_valid8[NREQ-1:0]    = req_valid;
    w_ptr3                = '0;
    w_ptr3[IDW-1:0]       = r_rr_ptr;
  end

  assign w_pick     = rr_pick(w_valid8, w_ptr3, NREQ);
  assign w_eligible = !rst && (r_state == RUN) && core_ready && (w_count < CW'(LATENCY));
  assign w_grant    = w_eligible && w_pick.found;

  // Each requester's sharing is masked by its own grant bit and the results
  // OR-reduced, so the select never combines share data from two requesters.
  always_comb begin
    req_ready = '0;
    w_pt      = '0;
    w_key     = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ready[i] = w_grant && (w_pick.idx == 3'(i));
      w_pt  = w_pt  | (req_sh_plaintext[i*SW +: SW] & {SW{req_ready[i]}});
      w_key = w_key | (req_sh_key[i*SW +: SW]       & {SW{req_ready[i]}});
    end
  end

  assign core_valid_in     = w_grant;
  assign core_sh_plaintext = w_pt;
  assign core_sh_key       = w_key;
  assign core_nrst         = ~rst;

  assign w_pop = !rst && core_cipher_valid && (w_count != '0);

  mskaes_tag_fifo #(
    .DEPTH (LATENCY),
    .W     (IDW),
    .CW    (CW)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_grant),
    .i_data  (w_pick.idx[IDW-1:0]),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign out_valid         = w_pop;
  assign out_id            = w_head;
  assign out_sh_ciphertext = core_sh_ciphertext;
  assign inflight          = w_count;
  assign flush_done        = r_flush_done;
  assign err_underflow     = r_err_underflow;

  // No pushes occur outside RUN, so the drained test only needs the pop.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (flush_req) w_state_nxt = DRAIN;
      DRAIN:   if ((w_count == '0) || ((w_count == CW'(1)) && w_pop)) w_state_nxt = DONE;
      DONE:    w_state_nxt = flush_req ? HOLD : RUN;
      HOLD:    if (!flush_req) w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= RUN;
      r_rr_ptr        <= '0;
      r_flush_done    <= 1'b0;
      r_err_underflow <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_done <= (r_state == DRAIN) && (w_state_nxt == DONE);
      if (core_cipher_valid && (w_count == '0)) r_err_underflow <= 1'b1;
      if (w_grant) begin
        r_rr_ptr <= (w_pick.idx == 3'(NREQ - 1)) ? '0 : w_pick.idx[IDW-1:0] + 1'b1;
      end
    end
  end

endmodule
